key_search_sequencer: RTL and testbench
=======================================

// Module: key_search_sequencer
// PURPOSE
//  Sequences one key-search run: latches target Hamming weight and number of keys wanted, pulls
//  candidates from the generator, keeps those whose weight equals the target and buffers them in
//  a FIFO. Sits between the candidate generator/weight counter and the key consumer.
//  Ends a run when enough keys are found, when the try budget runs out, or on abort.
// PARAMETERS
//  KEY_W      128    candidate/key width, bits
//  CNT_W      16     width of key-count and try counters
//  FIFO_DEPTH 4      output FIFO entries, power of 2, >=2
//  MAX_TRIES  65535  candidates examined per run before timeout, 1..2**CNT_W-1
// PORTS
//  in_clk            in   1      clock, rising edge
//  in_rst            in   1      asynchronous reset, active-high
//  in_start          in   1      1-cycle pulse, begins run; ignored unless IDLE
//  in_abort          in   1      cancels run from any state
//  in_target_weight  in   8      wanted number of ones, latched at start
//  in_key_count      in   CNT_W  keys wanted, latched at start
//  out_cand_req      out  1      sequencer accepts a candidate this cycle
//  in_cand_valid     in   1      generator presents candidate; transfer = valid & req
//  in_cand_key       in   KEY_W  candidate key
//  in_cand_weight    in   8      Hamming weight of in_cand_key, same cycle
//  out_key_valid     out  1      FIFO head valid
//  out_key           out  KEY_W  FIFO head; 0 when out_key_valid=0
//  in_key_ready      in   1      consumer pops head when valid & ready
//  out_busy          out  1      state != IDLE
//  out_done          out  1      1-cycle pulse at end of run, not on abort
//  out_timeout       out  1      sticky: last run hit MAX_TRIES; cleared by next start/abort
//  out_keys_found    out  CNT_W  matches in current/last run
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, all outputs 0, latched target/count 0.
//  FSM IDLE->SEARCH->DRAIN->DONE->IDLE.
//   IDLE: in_start clears found, tries, out_timeout and latches target/count. Count=0 goes straight to DONE.
//   SEARCH: out_cand_req=1 iff FIFO occupancy < FIFO_DEPTH (registered count; a same-cycle pop
//    does not raise req). Each transfer: tries+1. weight==target pushes key and adds found+1.
//    found reaching count -> DRAIN. Else tries reaching MAX_TRIES -> DRAIN and set out_timeout.
//    A match on the final try counts as found: completion wins, no timeout.
//   DRAIN: out_cand_req=0; go to DONE once FIFO empty, including the cycle of the last pop.
//   DONE: out_done=1 for one cycle, then IDLE. out_keys_found holds until next start.
//  Latency: matching transfer in cycle N gives out_key_valid in N+1 if the FIFO was empty.
//  FIFO: first in, first out. Push and pop in the same cycle are both allowed. Pointers wrap modulo FIFO_DEPTH.
//  in_cand_valid without out_cand_req: ignored, no count. Consumer may pop in any state.
//  in_abort: next cycle IDLE, FIFO flushed, out_timeout cleared, no out_done. Abort beats start and transfer.
//  in_rst mid-run: immediate return to reset values; buffered keys are lost.
//  Counters saturate, never wrap.
// CONFIGURATION
//  KEY_SEARCH_STATS_EN defined: adds output out_tries [CNT_W] = candidates examined in current/last run.
//   Cleared on start/abort/reset, held after run.
//  Not defined: port absent. Internal try counter still drives the timeout.
// TESTING
//  1 target=3, count=2, generator sends 0x7, 0x3, 0xB, ready=1 -> keys 0x7, 0xB.
//    found=2, tries=3, one done pulse, timeout=0.
//  2 MAX_TRIES=4, count=1, no candidate matches -> after 4 transfers DRAIN->DONE, timeout=1, found=0.
//  3 ready=0, target matches all, count=6, DEPTH=4 -> req drops after 4 pushes.
//    Raise ready: 6 keys out in order, done after last pop.
//  4 abort 2 cycles after start with 1 key buffered -> next cycle busy=0, key_valid=0, no done.
//  5 in_key_count=0 with start -> done pulse 2 cycles after start, req never asserted.
//  6 MAX_TRIES=3, match only on third candidate, count=1 -> found=1, timeout=0, done.

Source files
------------

// File: rtl/key_search_sequencer.sv
// key_search_sequencer: runs one key search, buffering candidates of the target weight in a FIFO.
// Define KEY_SEARCH_STATS_EN to add the out_tries port.
module key_search_sequencer #(
    parameter int KEY_W      = 128,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_TRIES  = 65535
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_start,
    input  logic             in_abort,
    input  logic [7:0]       in_target_weight,
    input  logic [CNT_W-1:0] in_key_count,
    output logic             out_cand_req,
    input  logic             in_cand_valid,
    input  logic [KEY_W-1:0] in_cand_key,
    input  logic [7:0]       in_cand_weight,
    output logic             out_key_valid,
    output logic [KEY_W-1:0] out_key,
    input  logic             in_key_ready,
    output logic             out_busy,
    output logic             out_done,
    output logic             out_timeout,
    output logic [CNT_W-1:0] out_keys_found
`ifdef KEY_SEARCH_STATS_EN
    ,
    output logic [CNT_W-1:0] out_tries
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_TRIES);
    typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [7:0] target;
    logic [CNT_W-1:0] count, found, tries, found_inc, tries_inc;
    logic timeout, done, xfer, match, pop, hit_count, hit_max;
    logic [KEY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] occ;
    assign out_cand_req = (state == SEARCH) && (occ < FULL);
    assign xfer = out_cand_req & in_cand_valid & ~in_abort;
    assign match = xfer & (in_cand_weight == target);
    assign out_key_valid = occ != '0;
    assign out_key = out_key_valid ? mem[rd_ptr] : '0;
    assign pop = out_key_valid & in_key_ready;
    assign found_inc = (found == '1) ? found : found + 1'b1;
    assign tries_inc = (tries == '1) ? tries : tries + 1'b1;
    // completion takes priority over the try budget on the final candidate
    assign hit_count = match && (found_inc == count);
    assign hit_max = xfer && (tries_inc == MAX_T);
    assign out_busy = state != IDLE;
    assign out_done = done;
    assign out_timeout = timeout;
    assign out_keys_found = found;
`ifdef KEY_SEARCH_STATS_EN
    assign out_tries = tries;
`endif
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_start ? ((in_key_count == '0) ? DONE : SEARCH) : IDLE;
            SEARCH:  state_n = (hit_count || hit_max) ? DRAIN : SEARCH;
            DRAIN:   state_n = (occ == '0 || (occ == (AW+1)'(1) && pop)) ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
        if (in_abort) state_n = IDLE;
    end
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state   <= IDLE;
            target  <= '0;
            count   <= '0;
            found   <= '0;
            tries   <= '0;
            timeout <= 1'b0;
            done    <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
        end else begin
            state <= state_n;
            done  <= (state == DONE) && !in_abort;
            if (in_abort) begin
                tries   <= '0;
                timeout <= 1'b0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                occ     <= '0;
            end else begin
                if (state == IDLE && in_start) begin
                    target  <= in_target_weight;
                    count   <= in_key_count;
                    found   <= '0;
                    tries   <= '0;
                    timeout <= 1'b0;
                end
                if (xfer) tries <= tries_inc;
                if (match) found <= found_inc;
                if (hit_max && !hit_count) timeout <= 1'b1;
                if (match) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                occ <= occ + (AW+1)'(match) - (AW+1)'(pop);
            end
        end
    end
    always_ff @(posedge in_clk) begin
        if (match) mem[wr_ptr] <= in_cand_key;
    end
endmodule

// File: tb/tb_key_search_sequencer.sv
// tb_key_search_sequencer: directed and random runs checked cycle by cycle against a queue-based model.
module tb_key_search_sequencer;
    localparam int KW = 32;
    localparam int CW = 16;
    localparam int DEPTH = 4;
    localparam int MT = 8;
    logic in_clk, in_rst, in_start, in_abort, in_cand_valid, in_key_ready;
    logic [7:0] in_target_weight, in_cand_weight;
    logic [CW-1:0] in_key_count, out_keys_found;
    logic [KW-1:0] in_cand_key, out_key;
    logic out_cand_req, out_key_valid, out_busy, out_done, out_timeout;
`ifdef KEY_SEARCH_STATS_EN
    logic [CW-1:0] out_tries;
`endif
    key_search_sequencer #(.KEY_W(KW), .CNT_W(CW), .FIFO_DEPTH(DEPTH), .MAX_TRIES(MT)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_abort(in_abort),
        .in_target_weight(in_target_weight), .in_key_count(in_key_count),
        .out_cand_req(out_cand_req), .in_cand_valid(in_cand_valid), .in_cand_key(in_cand_key),
        .in_cand_weight(in_cand_weight), .out_key_valid(out_key_valid), .out_key(out_key),
        .in_key_ready(in_key_ready), .out_busy(out_busy), .out_done(out_done),
        .out_timeout(out_timeout), .out_keys_found(out_keys_found)
`ifdef KEY_SEARCH_STATS_EN
        , .out_tries(out_tries)
`endif
    );
    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    // model: phase 0 idle, 1 searching, 2 draining, 3 finishing
    int m_phase;
    logic [KW-1:0] q[$];
    int m_found, m_tries, m_count, m_target;
    bit m_timeout, m_done;
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic bit m_req();
        return m_phase == 1 && q.size() < DEPTH;
    endfunction
    task automatic model_reset();
        m_phase = 0; q.delete(); m_found = 0; m_tries = 0; m_count = 0; m_target = 0;
        m_timeout = 0; m_done = 0;
    endtask
    task automatic model_step();
        bit req, pop, hit;
        if (in_rst) begin
            model_reset();
            return;
        end
        req = m_req();
        pop = q.size() > 0 && in_key_ready;
        m_done = m_phase == 3 && !in_abort;
        if (in_abort) begin
            q.delete(); m_timeout = 0; m_tries = 0; m_phase = 0;
            return;
        end
        if (pop) void'(q.pop_front());
        case (m_phase)
            0: if (in_start) begin
                m_found = 0; m_tries = 0; m_timeout = 0;
                m_target = in_target_weight; m_count = in_key_count;
                m_phase = (m_count == 0) ? 3 : 1;
            end
            1: if (req && in_cand_valid) begin
                if (m_tries < 65535) m_tries++;
                hit = in_cand_weight == m_target;
                if (hit) begin
                    q.push_back(in_cand_key);
                    if (m_found < 65535) m_found++;
                end
                if (hit && m_found == m_count) m_phase = 2;
                else if (m_tries == MT) begin
                    m_phase = 2; m_timeout = 1;
                end
            end
            2: if (q.size() == 0) m_phase = 3;
            default: m_phase = 0;
        endcase
    endtask
    task automatic compare_all();
        chk("busy", 128'(out_busy), 128'(m_phase != 0));
        chk("cand_req", 128'(out_cand_req), 128'(m_req()));
        chk("key_valid", 128'(out_key_valid), 128'(q.size() > 0));
        chk("key", 128'(out_key), 128'(q.size() > 0 ? q[0] : '0));
        chk("done", 128'(out_done), 128'(m_done));
        chk("timeout", 128'(out_timeout), 128'(m_timeout));
        chk("keys_found", 128'(out_keys_found), 128'(m_found));
`ifdef KEY_SEARCH_STATS_EN
        chk("tries", 128'(out_tries), 128'(m_tries));
`endif
        if (out_done) done_cnt++;
    endtask
    task automatic tick();
        @(posedge in_clk);
        model_step();
        @(negedge in_clk);
        compare_all();
    endtask
    task automatic start_run(input int tgt, input int cnt);
        in_target_weight = 8'(tgt);
        in_key_count = CW'(cnt);
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask
    task automatic send(input logic [KW-1:0] key, input int w);
        bit x;
        bit ok = 0;
        in_cand_valid = 1'b1;
        in_cand_key = key;
        in_cand_weight = 8'(w);
        for (int i = 0; i < 30 && !ok; i++) begin
            x = m_req();
            tick();
            ok = x;
        end
        in_cand_valid = 1'b0;
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL send_bound: observed no transfer expected transfer of %0h", key);
        end
    endtask
    task automatic wait_idle(input int bound);
        bit ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            ok = m_phase == 0 && q.size() == 0 && !m_done;
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL idle_bound: observed busy expected idle within %0d cycles", bound);
        end
    endtask
    initial begin
        in_rst = 1'b1; in_start = 0; in_abort = 0; in_target_weight = 0; in_key_count = 0;
        in_cand_valid = 0; in_cand_key = 0; in_cand_weight = 0; in_key_ready = 0;
        model_reset();
        @(negedge in_clk);
        compare_all();
        tick();
        in_rst = 1'b0;
        tick();
        // basic run: 0x7 and 0xB match weight 3
        in_key_ready = 1'b1;
        done_cnt = 0;
        start_run(3, 2);
        send(32'h7, 3); send(32'h3, 2); send(32'hB, 3);
        wait_idle(20);
        chk("t1_found", 128'(out_keys_found), 128'd2);
        chk("t1_timeout", 128'(out_timeout), 128'd0);
        chk("t1_done_pulses", 128'(done_cnt), 128'd1);
        // try budget exhausted with no match
        done_cnt = 0;
        start_run(200, 1);
        for (int i = 0; i < MT; i++) send(32'(i), 1);
        wait_idle(20);
        chk("t2_timeout", 128'(out_timeout), 128'd1);
        chk("t2_found", 128'(out_keys_found), 128'd0);
        chk("t2_done_pulses", 128'(done_cnt), 128'd1);
        // FIFO full back-pressure, then drain in order
        in_key_ready = 1'b0;
        done_cnt = 0;
        start_run(1, 6);
        for (int i = 0; i < 4; i++) send(32'(1) << i, 1);
        in_cand_valid = 1'b1; in_cand_key = 32'h10; in_cand_weight = 8'd1;
        repeat (3) tick();
        chk("t3_req_full", 128'(out_cand_req), 128'd0);
        chk("t3_key_head", 128'(out_key), 128'h1);
        in_key_ready = 1'b1;
        send(32'h10, 1); send(32'h20, 1);
        wait_idle(30);
        chk("t3_found", 128'(out_keys_found), 128'd6);
        chk("t3_done_pulses", 128'(done_cnt), 128'd1);
        // abort with one key buffered
        in_key_ready = 1'b0;
        done_cnt = 0;
        start_run(1, 5);
        send(32'h40, 1);
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        chk("t4_busy", 128'(out_busy), 128'd0);
        chk("t4_key_valid", 128'(out_key_valid), 128'd0);
        repeat (3) tick();
        chk("t4_no_done", 128'(done_cnt), 128'd0);
        // zero keys wanted: done two cycles after start, no request
        done_cnt = 0;
        start_run(1, 0);
        chk("t5_req_a", 128'(out_cand_req), 128'd0);
        chk("t5_done_a", 128'(out_done), 128'd0);
        tick();
        chk("t5_req_b", 128'(out_cand_req), 128'd0);
        chk("t5_done_b", 128'(out_done), 128'd1);
        tick();
        // match on the final try: completion, not timeout
        in_key_ready = 1'b1;
        done_cnt = 0;
        start_run(2, 1);
        for (int i = 0; i < MT - 1; i++) send(32'h1, 1);
        send(32'h3, 2);
        wait_idle(20);
        chk("t6_found", 128'(out_keys_found), 128'd1);
        chk("t6_timeout", 128'(out_timeout), 128'd0);
        chk("t6_done_pulses", 128'(done_cnt), 128'd1);
        // asynchronous reset mid-run drops buffered keys
        in_key_ready = 1'b0;
        start_run(1, 3);
        send(32'h55, 4);
        send(32'h80, 1);
        #2 in_rst = 1'b1;
        #1 model_reset();
        compare_all();
        chk("rst_key_valid", 128'(out_key_valid), 128'd0);
        tick();
        in_rst = 1'b0;
        tick();
        // random runs with ignored starts, back-pressure and occasional aborts
        for (int r = 0; r < 40; r++) begin
            bit fin = 0;
            start_run($urandom_range(5, 2), $urandom_range(5, 0));
            for (int c = 0; c < 300 && !fin; c++) begin
                in_cand_valid = ($urandom % 4) != 0;
                in_cand_key = $urandom & $urandom & $urandom;
                in_cand_weight = 8'($countones(in_cand_key));
                in_key_ready = ($urandom % 3) != 0;
                in_abort = ($urandom % 64) == 0;
                in_start = ($urandom % 8) == 0;
                tick();
                in_abort = 1'b0; in_start = 1'b0;
                fin = m_phase == 0 && q.size() == 0 && !m_done;
            end
            in_cand_valid = 1'b0;
            checks++;
            assert (fin) else begin
                errors++;
                $error("FAIL rand_bound: observed run %0d unfinished expected finished", r);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
